evaluador_golpes: RTL and testbench
===================================

# evaluador_golpes

Hit-judgement stage between the five drum buttons and the score display path. It debounces each button and compares every press against the note position on that lane at the fixed strike band. It accumulates the 13-bit score consumed by the binary-to-BCD converter and raises the sticky `perdio` flag consumed by the level state machine. The note/lane generator sits upstream; it supplies note positions and receives a per-lane consume pulse.

## Interface
- `POS_BANDA`, 384: Y coordinate of the strike band.
- `VENTANA`, 16: hit window half-width in pixels (inclusive).
- `DEB_CICLOS`, 250000: cycles a raw button must differ from its debounced state before the change is accepted (5 ms at 50 MHz).
- `PUNTOS_GOLPE`, 10: points added per hit.
- `MAX_FALLOS`, 5: number of misses that ends the game.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `enable`  in  1  game running (level machine "comenzar"); judging only when high.
- `boton`  in  5  raw, asynchronous drum buttons, active-high; bit i = lane i.
- `posL1`..`posL5`  in  10 each  Y position of the current note on lanes 1..5.
- `notaValida`  in  5  bit i high = lane i currently has a live note.
- `consumir`  out  5  one-cycle pulse: note on lane i is retired (hit or passed).
- `puntuacion`  out  13  accumulated score, saturating.
- `fallos`  out  3  miss count, saturating at `MAX_FALLOS`.
- `perdio`  out  1  sticky game-lost flag.

## Operation
- Reset values: `consumir`=0, `puntuacion`=0, `fallos`=0, `perdio`=0. FSM in INACTIVO. Debounced states are 0. Debounce counters are 0.
- Input path, per lane: 2-FF synchroniser, then debounce counter. The counter increments while the synced value ≠ the debounced state and clears when they are equal. When the count reaches `DEB_CICLOS`, the debounced state toggles and the counter clears.
- A debounced 0→1 produces a one-cycle `press[i]`. Debounce runs in all FSM states.
- FSM states:
  - INACTIVO: no judging. Goes to JUGANDO when `enable`=1.
  - JUGANDO: judges every cycle. Goes to INACTIVO when `enable`=0, with score and fallos held. Goes to PERDIDO when `fallos` reaches `MAX_FALLOS`.
  - PERDIDO: `perdio`=1, no judging, outputs frozen. Exits only on reset.
- Per-lane judgement, in JUGANDO only:
  - en_ventana = `notaValida[i]` and |posLi − `POS_BANDA`| ≤ `VENTANA`. Compute on 11-bit signed difference.
  - paso = `notaValida[i]` and posLi > `POS_BANDA` + `VENTANA`.
  - `press[i]` and en_ventana → hit: `consumir[i]`=1, add `PUNTOS_GOLPE`.
  - `press[i]` and not en_ventana → one miss.
  - paso → `consumir[i]`=1 and one miss.
  - A lane contributes at most one miss per cycle.
- Consume masking:
  - Lane i is masked from judgement for the one cycle following its `consumir` pulse.
  - Upstream deasserts `notaValida[i]` within that cycle.
  - A press landing in the masked cycle is discarded.
- Simultaneous lanes:
  - All five lanes are judged in parallel.
  - Score adds (hits × `PUNTOS_GOLPE`) in one update and saturates at 8191.
  - Fallos adds the miss count in one update and saturates at `MAX_FALLOS`.
  - Hits and misses in the same cycle both apply.
- Reaching `MAX_FALLOS` also freezes the score: hits in that same cycle still count.

## Timing
- Button edge to `press`: 2 sync cycles + `DEB_CICLOS` + 1.
- `press` or paso in cycle t → `consumir`, `puntuacion` and `fallos` registered at t+1.
- `perdio` asserts at t+1 of the update that reaches `MAX_FALLOS` (same edge as that `fallos` update). The FSM is in PERDIDO from that edge.
- `enable` is sampled each cycle. A deassert takes effect on the next edge; an event judged in the same cycle still commits.
- Reset mid-operation clears everything asynchronously, including in-flight debounce counts and pending pulses.

## Test plan
- Use `DEB_CICLOS`=4 for all cases.
- Hit: enable=1, notaValida[0]=1, posL1=380, hold boton[0] 10 cycles → one `consumir[0]` pulse 7 cycles after the edge; puntuacion 0→10; fallos stays 0.
- Bounce: toggle boton[2] every 2 cycles for 20 cycles, then hold low → no `press`, puntuacion and fallos unchanged.
- Pass miss: notaValida[3]=1, posL4 ramps 390→401 → `consumir[3]` once at the first cycle with pos=401; fallos=1; no second miss in the masked cycle.
- Simultaneous: lanes 0–4 all in window, all buttons pressed together → puntuacion +50 in a single update.
- Saturation: preload score via 820 hits, then 2 more → puntuacion=8191, not wrapped.
- Loss: 5 empty presses → fallos=5, perdio=1. Further hits leave puntuacion unchanged. Pulse reset low mid-run → all outputs 0 immediately; perdio stays 0 after release.

Source files
------------

// File: rtl/evaluador_golpes_if.sv
// Bus between the note/lane generator, the drum buttons and the hit-judgement stage.
interface evaluador_golpes_if;
    logic        enable;
    logic [4:0]  boton;
    logic [9:0]  posL1;
    logic [9:0]  posL2;
    logic [9:0]  posL3;
    logic [9:0]  posL4;
    logic [9:0]  posL5;
    logic [4:0]  notaValida;
    logic [4:0]  consumir;
    logic [12:0] puntuacion;
    logic [2:0]  fallos;
    logic        perdio;

    modport master (
        output enable, boton, posL1, posL2, posL3, posL4, posL5, notaValida,
        input  consumir, puntuacion, fallos, perdio
    );

    modport slave (
        input  enable, boton, posL1, posL2, posL3, posL4, posL5, notaValida,
        output consumir, puntuacion, fallos, perdio
    );
endinterface

// File: rtl/evaluador_golpes.sv
// Debounces the five drum buttons, judges presses against the strike band,
// and accumulates the saturating score, miss count and sticky lost flag.
module evaluador_golpes #(
    parameter int unsigned POS_BANDA    = 384,
    parameter int unsigned VENTANA      = 16,
    parameter int unsigned DEB_CICLOS   = 250000,
    parameter int unsigned PUNTOS_GOLPE = 10,
    parameter int unsigned MAX_FALLOS   = 5
) (
    input logic               clk,
    input logic               reset,
    evaluador_golpes_if.slave bus
);
    localparam int unsigned NLANES    = 5;
    localparam int unsigned CW        = $clog2(DEB_CICLOS + 1);
    localparam int unsigned SW        = 13;
    localparam int unsigned FW        = 3;
    localparam int unsigned SCORE_MAX = 8191;
    localparam logic signed [10:0] VEN_S = 11'(VENTANA);
    localparam logic signed [10:0] BANDA_S = 11'(POS_BANDA);

    typedef enum logic [1:0] {INACTIVO, JUGANDO, PERDIDO} estado_t;

    estado_t         estado_q, estado_d;
    logic [4:0]      sync1, sync2, deb, deb_q;
    logic [CW-1:0]   cnt [NLANES];
    logic [4:0]      press_c;
    logic [9:0]      pos [NLANES];
    logic [4:0]      hit_c, miss_c, cons_c;
    logic [2:0]      nhits_c, nmiss_c;
    logic [SW:0]     score_sum_c;
    logic [SW-1:0]   score_sat_c;
    logic [FW:0]     fallos_sum_c;
    logic [FW-1:0]   fallos_sat_c;
    logic [4:0]      cons_d;
    logic [SW-1:0]   score_d;
    logic [FW-1:0]   fallos_d;
    logic            perdio_d;

    // Synchroniser and per-lane debounce; runs regardless of game state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < NLANES; i++) cnt[i] <= '0;
        end else begin
            sync1 <= bus.boton;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < NLANES; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CICLOS - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press_c = deb & ~deb_q;

    always_comb begin
        pos[0] = bus.posL1;
        pos[1] = bus.posL2;
        pos[2] = bus.posL3;
        pos[3] = bus.posL4;
        pos[4] = bus.posL5;
    end

    // Parallel lane judgement; a lane consumed last cycle is masked this cycle
    always_comb begin
        logic signed [10:0] diff;
        logic               en_ventana, paso, libre;
        hit_c   = '0;
        miss_c  = '0;
        cons_c  = '0;
        nhits_c = '0;
        nmiss_c = '0;
        diff    = '0;
        for (int i = 0; i < NLANES; i++) begin
            diff       = $signed({1'b0, pos[i]}) - BANDA_S;
            en_ventana = bus.notaValida[i] && (diff >= -VEN_S) && (diff <= VEN_S);
            paso       = bus.notaValida[i] && (pos[i] > 10'(POS_BANDA + VENTANA));
            libre      = ~bus.consumir[i];
            hit_c[i]   = libre && press_c[i] && en_ventana;
            miss_c[i]  = libre && ((press_c[i] && !en_ventana) || paso);
            cons_c[i]  = hit_c[i] || (libre && paso);
            nhits_c    = nhits_c + 3'(hit_c[i]);
            nmiss_c    = nmiss_c + 3'(miss_c[i]);
        end
        score_sum_c  = {1'b0, bus.puntuacion} + (14'(nhits_c) * 14'(PUNTOS_GOLPE));
        score_sat_c  = (score_sum_c > 14'(SCORE_MAX)) ? SW'(SCORE_MAX) : score_sum_c[SW-1:0];
        fallos_sum_c = {1'b0, bus.fallos} + 4'(nmiss_c);
        fallos_sat_c = (fallos_sum_c > 4'(MAX_FALLOS)) ? FW'(MAX_FALLOS) : fallos_sum_c[FW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q       <= INACTIVO;
            bus.consumir   <= '0;
            bus.puntuacion <= '0;
            bus.fallos     <= '0;
            bus.perdio     <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            bus.consumir   <= cons_d;
            bus.puntuacion <= score_d;
            bus.fallos     <= fallos_d;
            bus.perdio     <= perdio_d;
        end
    end

    // Next state; the loss check wins over an enable drop in the same cycle
    always_comb begin
        estado_d = estado_q;
        cons_d   = '0;
        score_d  = bus.puntuacion;
        fallos_d = bus.fallos;
        perdio_d = bus.perdio;
        case (estado_q)
            INACTIVO: begin
                if (bus.enable) estado_d = JUGANDO;
            end
            JUGANDO: begin
                cons_d   = cons_c;
                score_d  = score_sat_c;
                fallos_d = fallos_sat_c;
                if (fallos_sat_c == FW'(MAX_FALLOS)) begin
                    estado_d = PERDIDO;
                    perdio_d = 1'b1;
                end else if (!bus.enable) begin
                    estado_d = INACTIVO;
                end
            end
            PERDIDO: begin
                perdio_d = 1'b1;
            end
            default: estado_d = INACTIVO;
        endcase
    end
endmodule

// File: tb/tb_evaluador_golpes.sv
// Randomised and directed bench for evaluador_golpes against a cycle-level
// behavioural model built from the judging rules.
module tb_evaluador_golpes;
    localparam int DEB    = 4;
    localparam int BANDA  = 384;
    localparam int VENT   = 16;
    localparam int PUNTOS = 10;
    localparam int MAXF   = 5;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    evaluador_golpes_if tif();

    evaluador_golpes #(
        .POS_BANDA(BANDA), .VENTANA(VENT), .DEB_CICLOS(DEB),
        .PUNTOS_GOLPE(PUNTOS), .MAX_FALLOS(MAXF)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [4:0] hist[$];
    logic [4:0] m_deb, m_press, m_cons;
    int         m_score, m_fallos;
    bit         m_perd, m_jug;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_tests++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, esp, $time);
        end
    endtask

    function automatic logic [31:0] salidas();
        return {10'b0, tif.consumir, tif.puntuacion, tif.fallos, tif.perdio};
    endfunction

    function automatic logic [31:0] esperado();
        return {10'b0, m_cons, 13'(m_score), 3'(m_fallos), m_perd};
    endfunction

    task automatic modelo_reset();
        hist.delete();
        repeat (DEB + 2) hist.push_back(5'b0);
        m_deb = '0; m_press = '0; m_cons = '0;
        m_score = 0; m_fallos = 0; m_perd = 1'b0; m_jug = 1'b0;
    endtask

    // One clock: predict from the inputs present before the edge, then compare
    task automatic ciclo();
        logic [4:0] b, v, cons, tog, nd;
        logic [9:0] p [5];
        int  nh, nm, sc, fa, d;
        bit  en, inw, pas, jn, pn, todas;
        b = tif.boton; v = tif.notaValida; en = tif.enable;
        p[0] = tif.posL1; p[1] = tif.posL2; p[2] = tif.posL3; p[3] = tif.posL4; p[4] = tif.posL5;
        cons = '0; tog = '0; nh = 0; nm = 0;
        sc = m_score; fa = m_fallos; jn = m_jug; pn = m_perd;
        if (rst_n) begin
            if (m_jug) begin
                for (int i = 0; i < 5; i++) begin
                    if (!m_cons[i]) begin
                        d   = int'(p[i]) - BANDA;
                        inw = v[i] && d >= -VENT && d <= VENT;
                        pas = v[i] && int'(p[i]) > BANDA + VENT;
                        if (m_press[i] && inw) begin
                            nh++;
                            cons[i] = 1'b1;
                        end else if (m_press[i] || pas) begin
                            nm++;
                            cons[i] = pas;
                        end
                    end
                end
                sc = m_score + PUNTOS * nh;
                if (sc > 8191) sc = 8191;
                fa = m_fallos + nm;
                if (fa > MAXF) fa = MAXF;
                if (fa == MAXF) begin
                    pn = 1'b1;
                    jn = 1'b0;
                end else begin
                    jn = en;
                end
            end else if (!m_perd) begin
                jn = en;
            end
            hist.push_front(b);
            void'(hist.pop_back());
            for (int i = 0; i < 5; i++) begin
                todas = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (hist[2 + k][i] == m_deb[i]) todas = 1'b0;
                tog[i] = todas;
            end
        end
        nd = m_deb ^ tog;
        @(posedge clk);
        if (rst_n) begin
            m_cons = cons; m_score = sc; m_fallos = fa; m_perd = pn; m_jug = jn;
            m_press = tog & nd;
            m_deb = nd;
        end else begin
            modelo_reset();
        end
        #1;
        verifica("salidas", salidas(), esperado());
    endtask

    task automatic ciclos(input int n);
        for (int i = 0; i < n; i++) ciclo();
    endtask

    task automatic pulso_reset();
        rst_n = 1'b0;
        #1;
        verifica("reset_async", salidas(), 32'h0);
        modelo_reset();
        ciclos(2);
        rst_n = 1'b1;
    endtask

    task automatic todos_pos(input logic [9:0] p);
        tif.posL1 = p; tif.posL2 = p; tif.posL3 = p; tif.posL4 = p; tif.posL5 = p;
    endtask

    task automatic golpe(input logic [4:0] m);
        tif.boton = m;
        ciclos(8);
        tif.boton = '0;
        ciclos(8);
    endtask

    int lat, npulsos, s0, delta;
    logic [4:0] cons_ev;
    int hold [5];

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0;
        tif.enable = 1'b0; tif.boton = '0; tif.notaValida = '0;
        todos_pos(10'd0);
        modelo_reset();
        #1;
        verifica("reset", salidas(), 32'h0);
        ciclos(3);
        rst_n = 1'b1;
        tif.enable = 1'b1;
        ciclos(2);

        // Hit on lane 0: consume 7 cycles after the button edge
        tif.posL1 = 10'd380; tif.notaValida = 5'b00001; tif.boton = 5'b00001;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            ciclo();
            if (tif.consumir[0] && lat < 0) begin
                lat = k;
                tif.notaValida = '0;
            end
        end
        verifica("hit_latencia", 32'(lat), 32'd7);
        tif.boton = '0;
        ciclos(10);
        verifica("hit_score", 32'(tif.puntuacion), 32'd10);
        verifica("hit_fallos", 32'(tif.fallos), 32'd0);

        // Bounce on lane 2 must never produce a press
        for (int k = 0; k < 10; k++) begin
            tif.boton[2] = ~tif.boton[2];
            ciclos(2);
        end
        tif.boton = '0;
        ciclos(10);
        verifica("rebote_score", 32'(tif.puntuacion), 32'd10);
        verifica("rebote_fallos", 32'(tif.fallos), 32'd0);

        // Note on lane 3 passes the band
        tif.notaValida = 5'b01000;
        npulsos = 0;
        for (int p = 390; p <= 401; p++) begin
            tif.posL4 = 10'(p);
            ciclo();
            if (tif.consumir[3]) npulsos++;
        end
        verifica("paso_consumir", 32'(tif.consumir), 32'h08);
        ciclo();
        if (tif.consumir[3]) npulsos++;
        tif.notaValida = '0;
        ciclos(2);
        verifica("paso_pulsos", 32'(npulsos), 32'd1);
        verifica("paso_fallos", 32'(tif.fallos), 32'd1);

        // All five lanes hit together: one +50 update
        tif.posL1 = 10'd370; tif.posL2 = 10'd384; tif.posL3 = 10'd399;
        tif.posL4 = 10'd368; tif.posL5 = 10'd400;
        tif.notaValida = 5'b11111;
        tif.boton = 5'b11111;
        s0 = int'(tif.puntuacion); delta = -1; cons_ev = '0;
        for (int k = 0; k < 12; k++) begin
            ciclo();
            if (delta < 0 && int'(tif.puntuacion) != s0) begin
                delta = int'(tif.puntuacion) - s0;
                cons_ev = tif.consumir;
            end
        end
        verifica("simul_delta", 32'(delta), 32'd50);
        verifica("simul_consumir", 32'(cons_ev), 32'h1f);
        tif.notaValida = '0;
        tif.boton = '0;
        ciclos(10);

        // Randomised play against the model
        for (int ep = 0; ep < 3; ep++) begin
            pulso_reset();
            tif.enable = 1'b1;
            for (int i = 0; i < 5; i++) hold[i] = 0;
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < 5; i++) begin
                    if (hold[i] == 0) begin
                        tif.boton[i] = ($urandom_range(0, 2) == 0);
                        hold[i] = $urandom_range(1, 12);
                    end else begin
                        hold[i]--;
                    end
                end
                tif.notaValida = 5'($urandom);
                tif.posL1 = 10'(($urandom_range(0, 49) == 0) ? $urandom_range(401, 420) : $urandom_range(340, 400));
                tif.posL2 = 10'(($urandom_range(0, 49) == 0) ? $urandom_range(401, 420) : $urandom_range(340, 400));
                tif.posL3 = 10'(($urandom_range(0, 49) == 0) ? $urandom_range(401, 420) : $urandom_range(340, 400));
                tif.posL4 = 10'(($urandom_range(0, 49) == 0) ? $urandom_range(401, 420) : $urandom_range(340, 400));
                tif.posL5 = 10'(($urandom_range(0, 49) == 0) ? $urandom_range(401, 420) : $urandom_range(340, 400));
                tif.enable = ($urandom_range(0, 19) != 0);
                if (ep == 1 && c == 250) pulso_reset();
                ciclo();
            end
        end

        // Score saturation
        tif.boton = '0; tif.notaValida = '0;
        pulso_reset();
        tif.enable = 1'b1;
        ciclos(2);
        todos_pos(10'd384);
        tif.notaValida = 5'b11111;
        for (int r = 0; r < 164; r++) golpe(5'b11111);
        verifica("sat_820", 32'(tif.puntuacion), 32'd8191);
        golpe(5'b00011);
        verifica("sat_822", 32'(tif.puntuacion), 32'd8191);
        verifica("sat_fallos", 32'(tif.fallos), 32'd0);

        // Loss after five empty presses, then frozen, then async reset
        tif.notaValida = '0;
        pulso_reset();
        tif.enable = 1'b1;
        ciclos(2);
        for (int r = 0; r < 5; r++) golpe(5'b00001);
        verifica("perdida_fallos", 32'(tif.fallos), 32'd5);
        verifica("perdida_flag", 32'(tif.perdio), 32'd1);
        tif.notaValida = 5'b11111;
        npulsos = 0;
        tif.boton = 5'b11111;
        for (int k = 0; k < 8; k++) begin
            ciclo();
            if (tif.consumir != 5'b0) npulsos++;
        end
        tif.boton = '0;
        ciclos(8);
        verifica("congelado_score", 32'(tif.puntuacion), 32'd0);
        verifica("congelado_consumir", 32'(npulsos), 32'd0);
        pulso_reset();
        ciclos(5);
        verifica("post_reset_perdio", 32'(tif.perdio), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
